// File: rtl/instr_decode.sv
// ============================================================================
// instr_decode : registered MIPS-subset decoder with one-slot control flush
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instruction,
  input  logic        InstrValid,
  input  logic [29:0] InstrPC,
  input  logic        BranchTaken,
  output logic        Jump,
  output logic [25:0] TargetInstr,
  output logic        JumpReg,
  output logic        Branch,
  output logic        InvZero,
  output logic [15:0] imm16,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  RegDstAddr,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        Link,
  output logic [31:0] LinkData,
  output logic        Illegal
);

  localparam logic [0:0] c_RUN   = 1'b0;
  localparam logic [0:0] c_FLUSH = 1'b1;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_FN_JR    = 6'h08;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;

  logic [0:0]  r_state;
  logic        w_legal, w_jump, w_jr, w_br, w_invz, w_rw, w_alusrc;
  logic        w_mw, w_m2r, w_link, w_run, w_take;
  logic [2:0]  w_aluop;
  logic [4:0]  w_dst;
  logic [29:0] w_pc_next;

  always_comb begin
    w_legal  = 1'b1;
    w_jump   = 1'b0;
    w_jr     = 1'b0;
    w_br     = 1'b0;
    w_invz   = 1'b0;
    w_rw     = 1'b0;
    w_alusrc = 1'b0;
    w_aluop  = 3'b000;
    w_mw     = 1'b0;
    w_m2r    = 1'b0;
    w_link   = 1'b0;
    w_dst    = 5'd0;
    case (Instruction[31:26])
      c_OP_RTYPE: begin
        case (Instruction[5:0])
          c_FN_ADD: begin w_rw = 1'b1; w_dst = Instruction[15:11]; end
          c_FN_SUB: begin w_rw = 1'b1; w_dst = Instruction[15:11]; w_aluop = 3'b001; end
          c_FN_SLT: begin w_rw = 1'b1; w_dst = Instruction[15:11]; w_aluop = 3'b010; end
          c_FN_JR:  w_jr = 1'b1;
          default:  w_legal = 1'b0;
        endcase
      end
      c_OP_ADDI: begin w_rw = 1'b1; w_alusrc = 1'b1; w_dst = Instruction[20:16]; end
      c_OP_XORI: begin
        w_rw = 1'b1; w_alusrc = 1'b1; w_aluop = 3'b011; w_dst = Instruction[20:16];
      end
      c_OP_LW: begin
        w_rw = 1'b1; w_alusrc = 1'b1; w_m2r = 1'b1; w_dst = Instruction[20:16];
      end
      c_OP_SW:  begin w_mw = 1'b1; w_alusrc = 1'b1; end
      c_OP_BEQ: begin w_br = 1'b1; w_aluop = 3'b001; end
      c_OP_BNE: begin w_br = 1'b1; w_invz = 1'b1; w_aluop = 3'b001; end
      c_OP_J:   w_jump = 1'b1;
      c_OP_JAL: begin w_jump = 1'b1; w_link = 1'b1; w_rw = 1'b1; w_dst = 5'd31; end
      default:  w_legal = 1'b0;
    endcase
  end

  // Only a valid, legal word seen in RUN reaches the outputs; all else is a bubble.
  assign w_run     = (r_state == c_RUN);
  assign w_take    = w_run & InstrValid & w_legal;
  assign w_pc_next = InstrPC + 30'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_RUN;
      Jump        <= 1'b0;
      TargetInstr <= '0;
      JumpReg     <= 1'b0;
      Branch      <= 1'b0;
      InvZero     <= 1'b0;
      imm16       <= '0;
      Rs          <= '0;
      Rt          <= '0;
      RegDstAddr  <= '0;
      RegWrite    <= 1'b0;
      ALUSrc      <= 1'b0;
      ALUOp       <= '0;
      MemWrite    <= 1'b0;
      MemToReg    <= 1'b0;
      Link        <= 1'b0;
      LinkData    <= '0;
      Illegal     <= 1'b0;
    end else begin
      Jump        <= w_take & w_jump;
      TargetInstr <= w_take ? Instruction[25:0] : '0;
      JumpReg     <= w_take & w_jr;
      Branch      <= w_take & w_br;
      InvZero     <= w_take & w_invz;
      imm16       <= w_take ? Instruction[15:0] : '0;
      Rs          <= w_take ? Instruction[25:21] : '0;
      Rt          <= w_take ? Instruction[20:16] : '0;
      RegDstAddr  <= w_take ? w_dst : '0;
      RegWrite    <= w_take & w_rw;
      ALUSrc      <= w_take & w_alusrc;
      ALUOp       <= w_take ? w_aluop : '0;
      MemWrite    <= w_take & w_mw;
      MemToReg    <= w_take & w_m2r;
      Link        <= w_take & w_link;
      LinkData    <= w_take ? {w_pc_next, 2'b00} : '0;
      Illegal     <= Illegal | (w_run & InstrValid & ~w_legal);
      // A jump and a taken branch in the same cycle still cost only one drop.
      if (w_run) begin
        if ((w_take && (w_jump || w_jr)) || BranchTaken)
          r_state <= c_FLUSH;
      end else if (InstrValid) begin
        r_state <= c_RUN;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_decode.sv
// ============================================================================
// tb_instr_decode : scoreboard bench for instr_decode, directed vectors
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_decode;

  typedef struct packed {
    logic        j;
    logic [25:0] tg;
    logic        jr;
    logic        br;
    logic        iz;
    logic [15:0] im;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic        src;
    logic [2:0]  op;
    logic        mw;
    logic        mr;
    logic        lk;
    logic [31:0] ld;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Instruction = '0;
  logic        InstrValid = 1'b0;
  logic [29:0] InstrPC = '0;
  logic        BranchTaken = 1'b0;
  logic        Jump, JumpReg, Branch, InvZero, RegWrite, ALUSrc;
  logic        MemWrite, MemToReg, Link, Illegal;
  logic [25:0] TargetInstr;
  logic [15:0] imm16;
  logic [4:0]  Rs, Rt, RegDstAddr;
  logic [2:0]  ALUOp;
  logic [31:0] LinkData;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_exp[$];
  string q_name[$];

  always #5 clk = ~clk;

  instr_decode dut (
    .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .InstrValid(InstrValid),
    .InstrPC(InstrPC), .BranchTaken(BranchTaken), .Jump(Jump),
    .TargetInstr(TargetInstr), .JumpReg(JumpReg), .Branch(Branch), .InvZero(InvZero),
    .imm16(imm16), .Rs(Rs), .Rt(Rt), .RegDstAddr(RegDstAddr), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .Link(Link), .LinkData(LinkData), .Illegal(Illegal)
  );

  function automatic exp_t actual();
    actual = {Jump, TargetInstr, JumpReg, Branch, InvZero, imm16, Rs, Rt, RegDstAddr,
              RegWrite, ALUSrc, ALUOp, MemWrite, MemToReg, Link, LinkData, Illegal};
  endfunction

  function automatic exp_t bub(input logic ill);
    bub = '0;
    bub.il = ill;
  endfunction

  // Field copies of a decoded word; control bits are set by each vector.
  function automatic exp_t fld(input logic [31:0] w, input logic [31:0] ld, input logic ill);
    fld = '0;
    fld.rs = w[25:21];
    fld.rt = w[20:16];
    fld.im = w[15:0];
    fld.tg = w[25:0];
    fld.ld = ld;
    fld.il = ill;
  endfunction

  task automatic compare(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (q_exp.size() > 0) compare(q_name.pop_front(), q_exp.pop_front());
  end

  task automatic drive(input logic [31:0] w, input logic v, input logic [29:0] pc,
                       input logic bt, input exp_t e, input string name);
    @(negedge clk);
    Instruction = w;
    InstrValid  = v;
    InstrPC     = pc;
    BranchTaken = bt;
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    InstrValid = 1'b0;
    BranchTaken = 1'b0;
    #1 compare("reset_async", bub(1'b0));
    repeat (cycles) @(posedge clk);
    #3 compare("reset_hold", bub(1'b0));
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    reset_pulse(3);

    e = fld(32'h20080005, 32'h4, 1'b0); e.rw = 1; e.src = 1; e.rd = 5'd8;
    drive(32'h20080005, 1, 30'd0, 0, e, "addi_first");
    e = fld(32'h00221820, 32'h8, 1'b0); e.rw = 1; e.rd = 5'd3;
    drive(32'h00221820, 1, 30'd1, 0, e, "add");
    e = fld(32'h00222022, 32'hC, 1'b0); e.rw = 1; e.rd = 5'd4; e.op = 3'b001;
    drive(32'h00222022, 1, 30'd2, 0, e, "sub");
    e = fld(32'h0022282A, 32'h10, 1'b0); e.rw = 1; e.rd = 5'd5; e.op = 3'b010;
    drive(32'h0022282A, 1, 30'd3, 0, e, "slt");
    e = fld(32'h0C000009, 32'h14, 1'b0); e.j = 1; e.lk = 1; e.rw = 1; e.rd = 5'd31;
    drive(32'h0C000009, 1, 30'd4, 0, e, "jal");
    drive(32'h00221820, 0, 30'd5, 0, bub(0), "flush_hold_invalid");
    drive(32'h00221820, 1, 30'd5, 0, bub(0), "jal_drop");
    e = fld(32'h8D090004, 32'h1C, 1'b0); e.rw = 1; e.src = 1; e.mr = 1; e.rd = 5'd9;
    drive(32'h8D090004, 1, 30'd6, 0, e, "lw");
    e = fld(32'hAD090008, 32'h20, 1'b0); e.mw = 1; e.src = 1;
    drive(32'hAD090008, 1, 30'd7, 0, e, "sw");
    e = fld(32'h392A00FF, 32'h24, 1'b0); e.rw = 1; e.src = 1; e.op = 3'b011; e.rd = 5'd10;
    drive(32'h392A00FF, 1, 30'd8, 0, e, "xori");
    e = fld(32'h10220002, 32'h28, 1'b0); e.br = 1; e.op = 3'b001;
    drive(32'h10220002, 1, 30'd9, 0, e, "beq");
    e = fld(32'h03E00008, 32'h2C, 1'b0); e.jr = 1;
    drive(32'h03E00008, 1, 30'd10, 0, e, "jr");
    drive(32'h08000002, 1, 30'd11, 0, bub(0), "j_dropped_after_jr");
    e = fld(32'h00221820, 32'h34, 1'b0); e.rw = 1; e.rd = 5'd3;
    drive(32'h00221820, 1, 30'd12, 0, e, "add_after_jr");
    e = fld(32'h15090003, 32'h38, 1'b0); e.br = 1; e.iz = 1; e.op = 3'b001;
    drive(32'h15090003, 1, 30'd13, 0, e, "bne");
    drive(32'h00000000, 0, 30'd14, 1, bub(0), "branch_taken_gap");
    drive(32'h00222022, 1, 30'd14, 0, bub(0), "bne_drop");
    e = fld(32'h08000002, 32'h40, 1'b0); e.j = 1;
    drive(32'h08000002, 1, 30'd15, 1, e, "j_with_taken");
    drive(32'h00221820, 1, 30'd16, 1, bub(0), "single_drop_bt_ignored");
    e = fld(32'h00221820, 32'h48, 1'b0); e.rw = 1; e.rd = 5'd3;
    drive(32'h00221820, 1, 30'd17, 0, e, "add_after_single_drop");
    e = fld(32'h00221820, 32'h0, 1'b0); e.rw = 1; e.rd = 5'd3;
    drive(32'h00221820, 1, 30'h3FFFFFFF, 0, e, "linkdata_wrap");
    e = fld(32'h08000002, 32'h4C, 1'b0); e.j = 1;
    drive(32'h08000002, 1, 30'd18, 0, e, "j_before_illegal_drop");
    drive(32'hFC000000, 1, 30'd19, 0, bub(0), "dropped_illegal_not_sticky");
    drive(32'hFC000000, 1, 30'd20, 0, bub(1), "illegal_op3f");
    e = fld(32'h20080005, 32'h58, 1'b1); e.rw = 1; e.src = 1; e.rd = 5'd8;
    drive(32'h20080005, 1, 30'd21, 0, e, "illegal_sticky_addi");
    drive(32'h00221821, 1, 30'd22, 0, bub(1), "illegal_funct");

    reset_pulse(2);
    e = fld(32'h20080005, 32'h4, 1'b0); e.rw = 1; e.src = 1; e.rd = 5'd8;
    drive(32'h20080005, 1, 30'd0, 0, e, "addi_after_reset");
    e = fld(32'h0C000009, 32'h14, 1'b0); e.j = 1; e.lk = 1; e.rw = 1; e.rd = 5'd31;
    drive(32'h0C000009, 1, 30'd4, 0, e, "jal_before_reset");
    @(posedge clk);
    reset_pulse(1);
    e = fld(32'h00221820, 32'h4, 1'b0); e.rw = 1; e.rd = 5'd3;
    drive(32'h00221820, 1, 30'd0, 0, e, "add_after_flush_reset");

    @(negedge clk);
    InstrValid = 1'b0;
    for (int i = 0; i < 10 && q_exp.size() > 0; i++) @(posedge clk);
    #4;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
